// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and default widths for the memory slot arbiter
//
// Purpose: owner/state enumerations and default bus widths used by the
// arbiter, its slot timer and the request/RAM interface bundle.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_VID = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_slot_arbiter_if.sv
// rtl/mem_slot_arbiter_if.sv - CPU/video request, response and RAM port bundle
//
// Purpose: groups the CPU bus, video fetch and RAM port signals of the arbiter.
// Modports:
//   slave  - arbiter side: takes requests and mem_rdata, drives acks,
//            read data, RAM strobes and slot_cpu
//   master - environment side (CPU, video scanner, RAM): the mirror image
interface mem_slot_arbiter_if #(
  parameter int ADDR_W = mem_arb_pkg::DEF_ADDR_W,
  parameter int DATA_W = mem_arb_pkg::DEF_DATA_W
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_ack;
  logic [DATA_W-1:0] vid_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              slot_cpu;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  vid_req, vid_addr,
    input  mem_rdata,
    output cpu_ack, cpu_rdata, vid_ack, vid_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output slot_cpu
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output vid_req, vid_addr,
    output mem_rdata,
    input  cpu_ack, cpu_rdata, vid_ack, vid_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  slot_cpu
  );

endinterface

// File: rtl/mem_slot_timer.sv
// rtl/mem_slot_timer.sv - slot counter and CPU/video slot ownership timer
//
// Purpose: counts CLOCK_50 cycles within a slot and alternates slot ownership.
// Ports:
//   CLOCK_50 - clock, rising edge
//   reset    - asynchronous, active-high; cnt=0, slot_cpu=1
//   cnt      - position inside the current slot, 0..SLOT_CYCLES-1
//   wrap     - high in the last cycle of a slot (cnt wraps on the next edge)
//   sample   - high at the request sample point (last cycle of a slot)
//   slot_cpu - registered, 1 while the current slot belongs to the CPU
module mem_slot_timer #(
  parameter int SLOT_CYCLES = 4,
  parameter int CNT_W       = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             sample,
  output logic             slot_cpu
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SLOT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             slot_cpu_q, slot_cpu_d;

  always_comb begin
    wrap       = (cnt_q == LAST_CNT);
    cnt_d      = wrap ? '0 : cnt_q + CNT_W'(1);
    slot_cpu_d = wrap ? ~slot_cpu_q : slot_cpu_q;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      slot_cpu_q <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      slot_cpu_q <= slot_cpu_d;
    end
  end

  // The owner of the upcoming slot is decided in the slot's last cycle.
  assign sample   = wrap;
  assign cnt      = cnt_q;
  assign slot_cpu = slot_cpu_q;

endmodule

// File: rtl/mem_slot_arbiter.sv
// rtl/mem_slot_arbiter.sv - time-slot arbiter sharing one RAM port between CPU and video
//
// Purpose: alternating CPU/video slots, at most one RAM transaction per slot,
// ISSUE/WAIT/DONE timeline per transaction, all outputs registered.
// Ports:
//   CLOCK_50 - sole clock, rising edge
//   reset    - asynchronous, active-high; aborts any in-flight transaction
//   bus      - mem_slot_arbiter_if.slave: cpu_req/we/addr/wdata -> cpu_ack/rdata,
//              vid_req/addr -> vid_ack/rdata, mem_en/we/addr/wdata <- mem_rdata,
//              slot_cpu
// Build option: MEM_ARB_SLOT_LEND_EN lends an owner-idle slot to the other requester.
module mem_slot_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SLOT_CYCLES = 4,
  parameter int MEM_LAT     = 1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  mem_slot_arbiter_if.slave bus
);

  localparam int               CNT_W   = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(MEM_LAT);

  logic [CNT_W-1:0] cnt;
  logic             wrap;
  logic             sample;
  logic             slot_cpu;

  mem_slot_timer #(
    .SLOT_CYCLES (SLOT_CYCLES),
    .CNT_W       (CNT_W)
  ) u_timer (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .cnt      (cnt),
    .wrap     (wrap),
    .sample   (sample),
    .slot_cpu (slot_cpu)
  );

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              txn_we_q, txn_we_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              vid_ack_q, vid_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;

  logic   next_slot_cpu;
  logic   cpu_ok, vid_ok;
  logic   sel_valid;
  owner_e sel_owner;
  logic   issue_go;
  logic   capture_go;

  // Selection for the upcoming slot. In S_DONE the requester being acked
  // still has req high from the finished transaction, so it is excluded;
  // this only matters when SLOT_CYCLES == MEM_LAT+2 and DONE is the sample cycle.
  always_comb begin
    next_slot_cpu = slot_cpu ^ wrap;
    cpu_ok = bus.cpu_req && !(state_q == S_DONE && owner_q == OWN_CPU);
    vid_ok = bus.vid_req && !(state_q == S_DONE && owner_q == OWN_VID);
    sel_valid = 1'b0;
    sel_owner = OWN_CPU;
    if (next_slot_cpu && cpu_ok) begin
      sel_valid = 1'b1;
      sel_owner = OWN_CPU;
    end else if (!next_slot_cpu && vid_ok) begin
      sel_valid = 1'b1;
      sel_owner = OWN_VID;
    end
`ifdef MEM_ARB_SLOT_LEND_EN
    // Owner has nothing to do: lend the slot, owner keeps priority above.
    else if (cpu_ok) begin
      sel_valid = 1'b1;
      sel_owner = OWN_CPU;
    end else if (vid_ok) begin
      sel_valid = 1'b1;
      sel_owner = OWN_VID;
    end
`endif
    issue_go   = sample && sel_valid && (state_q == S_IDLE || state_q == S_DONE);
    capture_go = (state_q == S_WAIT) && (cnt == LAT_CNT);
  end

  // FSM state register
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (issue_go) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (capture_go) state_d = S_DONE;
      S_DONE:  state_d = issue_go ? S_ISSUE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: next values of the output registers. Request fields are
  // latched on the sample edge so they are stable throughout ISSUE.
  always_comb begin
    owner_d     = owner_q;
    txn_we_d    = txn_we_q;
    mem_en_d    = issue_go;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_ack_d   = 1'b0;
    vid_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    vid_rdata_d = vid_rdata_q;

    if (issue_go) begin
      owner_d = sel_owner;
      if (sel_owner == OWN_CPU) begin
        txn_we_d    = bus.cpu_we;
        mem_we_d    = bus.cpu_we;
        mem_addr_d  = bus.cpu_addr;
        mem_wdata_d = bus.cpu_wdata;
      end else begin
        txn_we_d   = 1'b0;
        mem_addr_d = bus.vid_addr;
      end
    end

    if (capture_go) begin
      if (owner_q == OWN_CPU) begin
        cpu_ack_d = 1'b1;
        if (!txn_we_q) cpu_rdata_d = bus.mem_rdata;
      end else begin
        vid_ack_d   = 1'b1;
        vid_rdata_d = bus.mem_rdata;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      owner_q     <= OWN_CPU;
      txn_we_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      vid_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
    end else begin
      owner_q     <= owner_d;
      txn_we_q    <= txn_we_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      vid_ack_q   <= vid_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_rdata_q <= vid_rdata_d;
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.vid_ack   = vid_ack_q;
  assign bus.vid_rdata = vid_rdata_q;
  assign bus.slot_cpu  = slot_cpu;

endmodule

// File: tb/tb_mem_slot_arbiter.sv
// tb/tb_mem_slot_arbiter.sv - self-checking bench for mem_slot_arbiter
module tb_mem_slot_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int SC = 4;
  localparam int ML = 1;

`ifdef MEM_ARB_SLOT_LEND_EN
  localparam int LEND = 1;
`else
  localparam int LEND = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  mem_slot_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_slot_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .SLOT_CYCLES (SC),
    .MEM_LAT     (ML)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  typedef struct {
    owner_e          owner;
    logic            we;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW-1:0]   rdata;
  } txn_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  txn_t exp_q[$];
  txn_t pend;
  bit   pend_v = 0;
  int   pend_t = 0;
  int   cyc = 0;
  int   m_cnt;
  logic m_slot_cpu;
  logic [DW-1:0] m_cpu_rdata = '0;
  logic [DW-1:0] m_vid_rdata = '0;
  int   n_cpu_ack = 0;
  int   n_vid_ack = 0;
  int   n_mem_en  = 0;

  // RAM model, read latency ML=1, plus a preload port for the bench
  logic [DW-1:0] ram [0:65535];
  logic          pl_en;
  logic [AW-1:0] pl_a;
  logic [DW-1:0] pl_d;
  always @(posedge clk) begin
    if (pl_en) ram[pl_a] <= pl_d;
    else if (bus.mem_en && bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= ram[bus.mem_addr];
  end

  // Slot reference: cnt 0..SC-1, CPU slot first after reset
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt      <= 0;
      m_slot_cpu <= 1'b1;
    end else begin
      m_cnt <= (m_cnt == SC - 1) ? 0 : m_cnt + 1;
      if (m_cnt == SC - 1) m_slot_cpu <= !m_slot_cpu;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected transaction for the upcoming slot, decided at the sample point
  task automatic predict();
    txn_t t;
    bit   nom_cpu;
    bit   go;
    nom_cpu = !m_slot_cpu;
    go      = 1'b1;
    t.owner = OWN_CPU;
    t.we    = 1'b0;
    t.addr  = '0;
    t.wdata = '0;
    if (nom_cpu && bus.cpu_req) t.owner = OWN_CPU;
    else if (!nom_cpu && bus.vid_req) t.owner = OWN_VID;
`ifdef MEM_ARB_SLOT_LEND_EN
    else if (bus.cpu_req) t.owner = OWN_CPU;
    else if (bus.vid_req) t.owner = OWN_VID;
`endif
    else go = 1'b0;
    if (go) begin
      if (t.owner == OWN_CPU) begin
        t.we    = bus.cpu_we;
        t.addr  = bus.cpu_addr;
        t.wdata = bus.cpu_wdata;
      end else begin
        t.addr = bus.vid_addr;
      end
      t.rdata = ram[t.addr];
      exp_q.push_back(t);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && m_cnt == SC - 1) predict();
  end

  // Output monitor: pops the scoreboard on mem_en, checks acks and held read data
  always @(negedge clk) begin
    if (!rst) begin : mon
      bit exp_en, exp_ca, exp_va;
      if (bus.mem_en) n_mem_en++;
      if (bus.cpu_ack) n_cpu_ack++;
      if (bus.vid_ack) n_vid_ack++;
      exp_en = (m_cnt == 0) && (exp_q.size() != 0);
      chk("mem_en", 32'(bus.mem_en), 32'(exp_en));
      if (exp_en) begin
        pend   = exp_q.pop_front();
        pend_v = 1'b1;
        pend_t = cyc;
        chk("mem_we", 32'(bus.mem_we), 32'(pend.we));
        chk("mem_addr", 32'(bus.mem_addr), 32'(pend.addr));
        if (pend.we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(pend.wdata));
      end
      exp_ca = pend_v && pend.owner == OWN_CPU && (cyc - pend_t == ML + 1);
      exp_va = pend_v && pend.owner == OWN_VID && (cyc - pend_t == ML + 1);
      chk("cpu_ack", 32'(bus.cpu_ack), 32'(exp_ca));
      chk("vid_ack", 32'(bus.vid_ack), 32'(exp_va));
      if (exp_ca || exp_va) begin
        pend_v = 1'b0;
        if (!pend.we) begin
          if (exp_ca) m_cpu_rdata = pend.rdata;
          else        m_vid_rdata = pend.rdata;
        end
      end
      chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(m_cpu_rdata));
      chk("vid_rdata", 32'(bus.vid_rdata), 32'(m_vid_rdata));
      chk("slot_cpu", 32'(bus.slot_cpu), 32'(m_slot_cpu));
    end
  end

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pl_en = 1'b1;
    pl_a  = a;
    pl_d  = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic wait_ack(input bit is_cpu, input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 6 * SC; i++) begin
      @(negedge clk);
      if (is_cpu ? bus.cpu_ack : bus.vid_ack) begin
        got = 1'b1;
        break;
      end
    end
    chk(tag, 32'(got), 32'd1);
  endtask

  task automatic cycles_to_mem_en(output int n);
    n = -1;
    for (int i = 1; i <= 6 * SC; i++) begin
      @(negedge clk);
      if (bus.mem_en) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic align(input bit any_slot, input bit want_cpu);
    bit ok = 1'b0;
    for (int i = 0; i < 4 * SC; i++) begin
      @(negedge clk);
      if (m_cnt == 0 && (any_slot || m_slot_cpu == want_cpu)) begin
        ok = 1'b1;
        break;
      end
    end
    chk("align", 32'(ok), 32'd1);
  endtask

  task automatic cpu_txn(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
    bus.cpu_we    = we;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    bus.cpu_req   = 1'b1;
    wait_ack(1'b1, tag);
    bus.cpu_req   = 1'b0;
  endtask

  task automatic vid_txn(input logic [AW-1:0] a, input string tag);
    bus.vid_addr = a;
    bus.vid_req  = 1'b1;
    wait_ack(1'b0, tag);
    bus.vid_req  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int c0, v0, e0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.vid_req   = 1'b0;
    bus.vid_addr  = '0;
    pl_en = 1'b0;
    pl_a  = '0;
    pl_d  = '0;
    rst   = 1'b1;

    preload(16'h1234, 8'hA5);
    preload(16'h2000, 8'h11);
    preload(16'h3000, 8'h22);
    preload(16'h0040, 8'h5E);

    // Reset values
    @(negedge clk);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst_cpu_ack", 32'(bus.cpu_ack), 32'd0);
    chk("rst_vid_ack", 32'(bus.vid_ack), 32'd0);
    chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
    chk("rst_vid_rdata", 32'(bus.vid_rdata), 32'd0);
    chk("rst_slot_cpu", 32'(bus.slot_cpu), 32'd1);
    rst = 1'b0;

    // CPU read
    cpu_txn(1'b0, 16'h1234, 8'h00, "cpu_rd_ack_wait");
    chk("cpu_rd_data", 32'(bus.cpu_rdata), 32'hA5);

    // CPU write: read data must not change
    cpu_txn(1'b1, 16'h0010, 8'h3C, "cpu_wr_ack_wait");
    chk("cpu_wr_rdata_held", 32'(bus.cpu_rdata), 32'hA5);
    @(negedge clk);
    chk("ram_after_write", 32'(ram[16'h0010]), 32'h3C);

    // Video read of the written location
    vid_txn(16'h0010, "vid_rd_ack_wait");
    chk("vid_rd_data", 32'(bus.vid_rdata), 32'h3C);

    // Late video request at cnt=0 of a VID slot
    align(1'b0, 1'b0);
    bus.vid_addr = 16'h3000;
    bus.vid_req  = 1'b1;
    cycles_to_mem_en(n);
    chk("late_vid_latency", 32'(n), (LEND != 0) ? 32'd4 : 32'd8);
    wait_ack(1'b0, "late_vid_ack_wait");
    bus.vid_req = 1'b0;
    chk("late_vid_data", 32'(bus.vid_rdata), 32'h22);

    // Contention: both held for eight slots
    align(1'b1, 1'b0);
    c0 = n_cpu_ack;
    v0 = n_vid_ack;
    e0 = n_mem_en;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 16'h2000;
    bus.vid_addr = 16'h3000;
    bus.cpu_req  = 1'b1;
    bus.vid_req  = 1'b1;
    repeat (8 * SC) @(negedge clk);
    bus.cpu_req = 1'b0;
    bus.vid_req = 1'b0;
    repeat (2 * SC) @(negedge clk);
    chk("contend_mem_en", 32'(n_mem_en - e0), 32'd8);
    chk("contend_cpu_acks", 32'(n_cpu_ack - c0), 32'd4);
    chk("contend_vid_acks", 32'(n_vid_ack - v0), 32'd4);

    // Video only for four slots: lent slots or strict TDM
    align(1'b1, 1'b0);
    v0 = n_vid_ack;
    bus.vid_addr = 16'h0040;
    bus.vid_req  = 1'b1;
    repeat (4 * SC) @(negedge clk);
    bus.vid_req = 1'b0;
    repeat (2 * SC) @(negedge clk);
    chk("vid_only_acks", 32'(n_vid_ack - v0), (LEND != 0) ? 32'd4 : 32'd2);

    // Reset during WAIT of a CPU read
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 16'h1234;
    bus.cpu_req  = 1'b1;
    cycles_to_mem_en(n);
    chk("pre_rst_issue_seen", 32'(n > 0), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    bus.cpu_req = 1'b0;
    exp_q.delete();
    pend_v      = 1'b0;
    m_cpu_rdata = '0;
    m_vid_rdata = '0;
    chk("midrst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("midrst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("midrst_cpu_ack", 32'(bus.cpu_ack), 32'd0);
    chk("midrst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
    chk("midrst_vid_rdata", 32'(bus.vid_rdata), 32'd0);
    chk("midrst_slot_cpu", 32'(bus.slot_cpu), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.cpu_addr = 16'h0040;
    bus.cpu_req  = 1'b1;
    cycles_to_mem_en(n);
    chk("post_rst_first_mem_en", 32'(n), (LEND != 0) ? 32'd4 : 32'd8);
    chk("post_rst_slot", 32'(m_slot_cpu), (LEND != 0) ? 32'd0 : 32'd1);
    wait_ack(1'b1, "post_rst_ack_wait");
    bus.cpu_req = 1'b0;
    chk("post_rst_data", 32'(bus.cpu_rdata), 32'h5E);

    repeat (2 * SC) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("no_pending", 32'(pend_v), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
